// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the 4-bit-opcode datapath: fetch/decode/exec/mem/wb
// sequencing with ready handshake, memory watchdog, illegal-op trap and retire counter.
module multicycle_control #(
  parameter int OPW     = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPW-1:0]   op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             i_or_d,
  output logic             ir_wr,
  output logic             pc_wr,
  output logic             pc_src,
  output logic             alu_src,
  output logic [2:0]       alu_op,
  output logic             reg_wr,
  output logic             reg_des,
  output logic             mem_to_reg,
  output logic             retired,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DEC   = 3'd2,
    S_EXEC  = 3'd3,
    S_MEM   = 3'd4,
    S_WB    = 3'd5,
    S_FAULT = 3'd7
  } state_e;

  localparam logic [OPW-1:0] OP_R    = OPW'(0);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(1);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(2);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(3);
  localparam logic [OPW-1:0] OP_NORI = OPW'(4);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(5);
  localparam logic [OPW-1:0] OP_BNE  = OPW'(6);
  localparam logic [OPW-1:0] OP_SLTI = OPW'(7);
  localparam logic [OPW-1:0] OP_LW   = OPW'(8);
  localparam logic [OPW-1:0] OP_SW   = OPW'(9);

  // Watchdog counter only needs to reach TIMEOUT-1.
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WLIM = (TIMEOUT == 0) ? '0 : WW'(TIMEOUT - 1);
  localparam bit WDOG_EN = (TIMEOUT != 0);

  state_e           state_q;
  logic [OPW-1:0]   op_q;
  logic [WW-1:0]    wcnt_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fault_q;
  logic [1:0]       fcode_q;

  logic is_br, is_mem, illegal, wdog_hit;
  assign is_br    = (op_q == OP_BEQ) || (op_q == OP_BNE);
  assign is_mem   = (op_q == OP_LW)  || (op_q == OP_SW);
  assign illegal  = (op_q > OP_SW);
  assign wdog_hit = WDOG_EN && !mem_ready && (wcnt_q == WLIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      wcnt_q  <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      fcode_q <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
          wcnt_q  <= '0;
        end
        S_FETCH: begin
          if (mem_ready) begin
            op_q    <= op;
            state_q <= S_DEC;
            wcnt_q  <= '0;
          end else if (wdog_hit) begin
            state_q <= S_FAULT;
            fault_q <= 1'b1;
            fcode_q <= 2'b10;
          end else begin
            wcnt_q <= wcnt_q + WW'(1);
          end
        end
        S_DEC: begin
          if (illegal) begin
            state_q <= S_FAULT;
            fault_q <= 1'b1;
            fcode_q <= 2'b01;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          wcnt_q <= '0;
          if (is_br) begin
            state_q <= S_FETCH;
            cnt_q   <= cnt_q + CNT_W'(1);
          end else if (is_mem) begin
            state_q <= S_MEM;
          end else begin
            state_q <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            wcnt_q <= '0;
            if (op_q == OP_SW) begin
              state_q <= S_FETCH;
              cnt_q   <= cnt_q + CNT_W'(1);
            end else begin
              state_q <= S_WB;
            end
          end else if (wdog_hit) begin
            state_q <= S_FAULT;
            fault_q <= 1'b1;
            fcode_q <= 2'b11;
          end else begin
            wcnt_q <= wcnt_q + WW'(1);
          end
        end
        S_WB: begin
          state_q <= S_FETCH;
          wcnt_q  <= '0;
          cnt_q   <= cnt_q + CNT_W'(1);
        end
        S_FAULT: state_q <= S_FAULT;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Strobes decode from state/op_q only (plus ready/zero), so async reset clears them at once.
  always_comb begin
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    i_or_d     = 1'b0;
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    pc_src     = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 3'b000;
    reg_wr     = 1'b0;
    reg_des    = 1'b0;
    mem_to_reg = 1'b0;
    retired    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_rd = 1'b1;
        ir_wr  = mem_ready;
        pc_wr  = mem_ready;
      end
      S_EXEC: begin
        alu_src = !((op_q == OP_R) || is_br);
        case (op_q)
          OP_R:           alu_op = 3'b010;
          OP_ADDI:        alu_op = 3'b011;
          OP_ANDI:        alu_op = 3'b100;
          OP_ORI:         alu_op = 3'b101;
          OP_NORI:        alu_op = 3'b110;
          OP_BEQ, OP_BNE: alu_op = 3'b001;
          OP_SLTI:        alu_op = 3'b111;
          default:        alu_op = 3'b000;
        endcase
        if (is_br) begin
          pc_src  = 1'b1;
          pc_wr   = (op_q == OP_BEQ) ? zero : !zero;
          retired = 1'b1;
        end
      end
      S_MEM: begin
        i_or_d  = 1'b1;
        mem_rd  = (op_q == OP_LW);
        mem_wr  = (op_q == OP_SW);
        retired = (op_q == OP_SW) && mem_ready;
      end
      S_WB: begin
        reg_wr     = 1'b1;
        reg_des    = (op_q == OP_R);
        mem_to_reg = (op_q == OP_LW);
        retired    = 1'b1;
      end
      default: ;
    endcase
  end

  assign instr_cnt  = cnt_q;
  assign fault      = fault_q;
  assign fault_code = fcode_q;
  assign state      = state_q;

endmodule
